// File: rtl/text_console_ctrl.sv
// text_console_ctrl
//   Byte-stream console controller for an 80x60 VGA text buffer. Accepts one
//   character per handshake and keeps track of a cursor. Interprets CR, LF,
//   BS and FF, and wraps automatically at the end of a row. It also runs
//   multi-cycle fill sequences: a full-screen clear, and an optional clear
//   of each newly entered row.
//
// Ports
//   clk, rst     : clock; synchronous active-high reset
//   s_valid_i    : input byte valid
//   s_char_i     : input byte
//   s_ready_o    : controller accepts a byte this cycle (combinational)
//   clear_i      : full-screen clear request, sampled in IDLE
//   char_o       : text-buffer write data (registered)
//   addr_o       : text-buffer write address, y*COLS+x (registered)
//   wen_o        : text-buffer write strobe, one write per cycle (registered)
//   cursor_x_o   : cursor column (registered)
//   cursor_y_o   : cursor row (registered)
//   busy_o       : high whenever the controller is not in IDLE
//
// Handshake: a byte transfers at a rising edge where s_valid_i && s_ready_o.
// s_ready_o is high only in IDLE with clear_i low, so clear_i takes priority
// over a byte offered in the same cycle. The effect of an accepted byte is
// visible in the cycle after the edge at which it was accepted.
module text_console_ctrl #(
  parameter int         COLS          = 80,
  parameter int         ROWS          = 60,
  parameter logic [7:0] CLEAR_CHAR    = 8'h20,
  parameter bit         LINE_CLEAR_EN = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid_i,
  input  logic [7:0]                    s_char_i,
  output logic                          s_ready_o,
  input  logic                          clear_i,
  output logic [7:0]                    char_o,
  output logic [$clog2(COLS*ROWS)-1:0]  addr_o,
  output logic                          wen_o,
  output logic [$clog2(COLS)-1:0]       cursor_x_o,
  output logic [$clog2(ROWS)-1:0]       cursor_y_o,
  output logic                          busy_o
);

  localparam int NCELL = COLS * ROWS;
  localparam int AW    = $clog2(NCELL);
  localparam int XW    = $clog2(COLS);
  localparam int YW    = $clog2(ROWS);
  // The fill index must be able to hold NCELL itself. That value marks the
  // trailing idle cycle of a fill sequence.
  localparam int FW    = $clog2(NCELL + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLEAR   = 2'd1,
    S_LINECLR = 2'd2
  } state_t;

  state_t          r_state;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [FW-1:0]   r_fill;
  logic [AW-1:0]   r_line_base;
  logic [7:0]      r_char;
  logic [AW-1:0]   r_addr;
  logic            r_wen;

  logic            w_accept;
  logic [YW-1:0]   w_next_y;
  logic [AW-1:0]   w_cur_addr;
  logic [AW-1:0]   w_line_base;

  assign s_ready_o   = (r_state == S_IDLE) && !clear_i;
  assign w_accept    = s_valid_i && s_ready_o;

  // Rows wrap circularly. There is no scrolling.
  assign w_next_y    = (r_y == YW'(ROWS - 1)) ? '0 : r_y + 1'b1;
  assign w_cur_addr  = AW'(r_y) * AW'(COLS) + AW'(r_x);
  assign w_line_base = AW'(w_next_y) * AW'(COLS);

  assign char_o      = r_char;
  assign addr_o      = r_addr;
  assign wen_o       = r_wen;
  assign cursor_x_o  = r_x;
  assign cursor_y_o  = r_y;
  assign busy_o      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_fill      <= '0;
      r_line_base <= '0;
      r_char      <= '0;
      r_addr      <= '0;
      r_wen       <= 1'b0;
    end else begin
      // The strobe defaults low. r_addr and r_char hold between writes.
      r_wen <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear_i) begin
            r_state <= S_CLEAR;
            r_fill  <= '0;
          end else if (w_accept) begin
            case (s_char_i)
              8'h0D: begin
                r_x <= '0;
              end
              8'h0A: begin
                r_x <= '0;
                r_y <= w_next_y;
                if (LINE_CLEAR_EN) begin
                  r_state     <= S_LINECLR;
                  r_fill      <= '0;
                  r_line_base <= w_line_base;
                end
              end
              8'h08: begin
                if (r_x != '0) begin
                  r_x    <= r_x - 1'b1;
                  r_wen  <= 1'b1;
                  r_addr <= w_cur_addr - 1'b1;
                  r_char <= CLEAR_CHAR;
                end
              end
              8'h0C: begin
                r_state <= S_CLEAR;
                r_fill  <= '0;
              end
              default: begin
                r_wen  <= 1'b1;
                r_addr <= w_cur_addr;
                r_char <= s_char_i;
                if (r_x == XW'(COLS - 1)) begin
                  // Autowrap is a row change, the same as LF.
                  r_x <= '0;
                  r_y <= w_next_y;
                  if (LINE_CLEAR_EN) begin
                    r_state     <= S_LINECLR;
                    r_fill      <= '0;
                    r_line_base <= w_line_base;
                  end
                end else begin
                  r_x <= r_x + 1'b1;
                end
              end
            endcase
          end
        end

        // One write per cycle for fill indices 0..NCELL-1. The cycle at
        // index NCELL has no write and hands back to IDLE.
        S_CLEAR: begin
          if (r_fill == FW'(NCELL)) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
          end else begin
            r_wen  <= 1'b1;
            r_addr <= AW'(r_fill);
            r_char <= CLEAR_CHAR;
            r_fill <= r_fill + 1'b1;
          end
        end

        // Same shape as CLEAR, but covers COLS cells from the new row base.
        S_LINECLR: begin
          if (r_fill == FW'(COLS)) begin
            r_state <= S_IDLE;
          end else begin
            r_wen  <= 1'b1;
            r_addr <= r_line_base + AW'(r_fill);
            r_char <= CLEAR_CHAR;
            r_fill <= r_fill + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/text_console_ctrl.md
Name: text_console_ctrl

Overview:
- Byte-stream console controller that sequences the 80x60 text-buffer write port (char/addr/wen) of the VGA text-mode display.
- Accepts one character per valid/ready handshake and tracks a cursor.
- Interprets CR/LF/BS/FF and performs autowrap.
- Runs multi-cycle fill sequences: full-screen clear, and a clear of each newly entered line.

Parameters:
- COLS, 80, characters per row.
- ROWS, 60, rows per screen.
- CLEAR_CHAR, 8'h20, code written by clear and backspace operations.
- LINE_CLEAR_EN, 1, when 1 every row change (LF or autowrap) blanks the new row.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- s_valid_i  input  1  character byte valid
- s_char_i  input  8  character byte
- s_ready_o  output  1  controller can accept a byte this cycle
- clear_i  input  1  request a full-screen clear (sampled in IDLE)
- char_o  output  8  text-buffer write data
- addr_o  output  $clog2(COLS*ROWS)  text-buffer write address, row-major: y*COLS+x
- wen_o  output  1  text-buffer write strobe, one write per cycle
- cursor_x_o  output  $clog2(COLS)  current cursor column
- cursor_y_o  output  $clog2(ROWS)  current cursor row
- busy_o  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, cursor=(0,0), wen_o=0, char_o=0, addr_o=0, busy_o=0.
  - Reset does not clear buffer contents.
  - Reset asserted mid-CLEAR or mid-LINECLR aborts the sequence at that edge.
- Registered outputs: char_o, addr_o, wen_o and the cursor outputs are all registered.
- s_ready_o = (state==IDLE) && !clear_i. Combinational; clear_i has priority over s_valid_i.
- A byte is accepted at the edge where s_valid_i && s_ready_o. Call that edge k. Its action is visible in cycle k+1.
- States: IDLE, CLEAR, LINECLR.
- IDLE, clear_i=1:
  - Go to CLEAR with fill index=0.
  - Cursor is set to (0,0) when CLEAR completes.
- IDLE, accepted byte:
  - 0x0D (CR): x=0, no write.
  - 0x0A (LF): x=0, y=(y==ROWS-1)?0:y+1, no write. This is a row change.
  - 0x08 (BS):
    - If x>0: x=x-1 and write CLEAR_CHAR at (x-1,y).
    - If x==0: no write, cursor unchanged.
  - 0x0C (FF): identical to clear_i.
  - Any other code, 0x00-0xFF including other controls, is written as a glyph.
    - Write s_char_i at addr y*COLS+x, with wen_o=1 for exactly one cycle.
    - Then x=x+1. If x==COLS-1: x=0 and y advances with wrap (a row change).
- Row change with LINE_CLEAR_EN=1:
  - State goes to LINECLR at edge k.
  - Writes CLEAR_CHAR to (new_y*COLS + 0..COLS-1), one per cycle, in cycles k+2..k+1+COLS.
  - Returns to IDLE; s_ready_o is high again in cycle k+2+COLS.
  - Cycle k+1 carries the glyph write (autowrap) or no write (LF).
- Row change with LINE_CLEAR_EN=0: remain in IDLE.
- CLEAR:
  - Writes CLEAR_CHAR to addresses 0..COLS*ROWS-1 ascending, one per cycle, wen_o=1 every cycle (COLS*ROWS cycles).
  - The last write is followed by IDLE with cursor=(0,0).
  - clear_i and s_valid_i are ignored during CLEAR; a new clear_i is honoured only once back in IDLE.
- Bottom wrap: y=ROWS-1 wraps to 0. There is no scrolling; the buffer is circular by row.
- Write strobe: wen_o=0 in every cycle that has no write. addr_o and char_o hold their last values when wen_o=0.
- Arithmetic: x and y counters wrap exactly at COLS-1 and ROWS-1. The address must never exceed COLS*ROWS-1.

Test Plan:
- Reset, then send 'A','B' back-to-back.
  - Required: wen_o pulses at addr 0 (0x41) then addr 1 (0x42).
  - Required: cursor ends at (2,0); s_ready_o stays high throughout.
- Cursor at (79,0), send 'Z' (LINE_CLEAR_EN=1).
  - Required: write 0x5A at addr 79; cursor (0,1).
  - Required: 80 writes of 0x20 at addr 80..159; s_ready_o low for 81 cycles.
- Cursor at (5,59), send 0x0A.
  - Required: no write in k+1; cursor (0,0).
  - Required: line clear of addr 0..79.
- Cursor at (3,2), send 0x08.
  - Required: write 0x20 at addr 162; cursor (2,2).
  - Repeat at x=0: no write, cursor unchanged.
- clear_i pulse with s_valid_i=1 in the same cycle.
  - Required: byte not accepted; 4800 consecutive writes of 0x20 at addr 0..4799; busy_o high; then cursor (0,0).
- Assert rst at fill index 1000 of a clear.
  - Required: next cycle wen_o=0, busy_o=0, cursor (0,0).
  - Required: 'Q' sent afterwards is written at addr 0.
